// File: rtl/ft2232h_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ft2232h_tx_arbiter
// Purpose  : Round-robin frame scheduler for the FT2232H synchronous-FIFO
//            transmit path. It grants one of two frame sources at a time and
//            wraps the granted payload as
//              SYNC_BYTE, HDR={grant_id,seq[6:0]}, LEN, payload..., CSUM
//            where CSUM is the XOR of HDR, LEN and every payload byte.
//            When TXE# is held low it sends one byte per clock.
// Ports    : clk        60 MHz FT2232H CLKOUT, rising edge
//            rst_n      asynchronous active-low reset
//            txe_n      FT2232H TXE#, low = chip accepts a byte
//            wr_n       FT2232H WR#, low = data_out holds a pending byte
//            data_out   FT2232H D[7:0]
//            req[1:0]   per-source frame request (level, whole frame buffered)
//            len0/len1  payload byte count per source, sampled at grant
//            src_data0/1  first-word-fall-through payload byte per source
//            pop[1:0]   one-cycle strobe per payload byte taken
//            done[1:0]  one-cycle pulse after the frame's last byte is accepted
//            busy       high in every state except IDLE
// Revision : 1.0 - initial release
// ============================================================================
module ft2232h_tx_arbiter #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       txe_n,
  output logic       wr_n,
  output logic [7:0] data_out,
  input  logic [1:0] req,
  input  logic [7:0] len0,
  input  logic [7:0] len1,
  input  logic [7:0] src_data0,
  input  logic [7:0] src_data1,
  output logic [1:0] pop,
  output logic [1:0] done,
  output logic       busy
);

  // Each state names the last byte loaded into the output register; the
  // sequencer offers the following byte while in that state. CSUM is the
  // state that offers the checksum, DRAIN waits for it to be accepted.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_HDR   = 3'd2,
    S_LEN   = 3'd3,
    S_DATA  = 3'd4,
    S_CSUM  = 3'd5,
    S_DRAIN = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       grant;       // source owning the current frame
  logic       last_grant;  // round-robin pointer
  logic [7:0] len_q;       // latched payload length
  logic [7:0] cnt;         // payload bytes loaded so far
  logic [7:0] csum;        // running XOR of HDR, LEN and payload
  logic [6:0] seq0;
  logic [6:0] seq1;

  logic       accept;
  logic       room;
  logic       load;
  logic       pick;
  logic       offer_vld;
  logic       offer_pay;
  logic       offer_sum;
  logic [7:0] offer_byte;
  logic [7:0] cur_payload;
  logic [7:0] hdr_byte;

  assign accept      = ~wr_n & ~txe_n;
  // The register can take a new byte when it is empty or its byte leaves now.
  assign room        = wr_n | accept;
  assign load        = offer_vld & room;

  // Contention goes to the source not granted last; otherwise the only
  // requester wins.
  assign pick        = (req == 2'b11) ? ~last_grant : req[1];

  assign cur_payload = grant ? src_data1 : src_data0;
  assign hdr_byte    = {grant, (grant ? seq1 : seq0)};

  always_comb begin
    state_nxt  = state;
    offer_vld  = 1'b0;
    offer_pay  = 1'b0;
    offer_sum  = 1'b0;
    offer_byte = 8'h00;
    case (state)
      S_IDLE: begin
        // Only start on an empty output stage so grant and LEN latch cleanly.
        if ((req != 2'b00) && wr_n) begin
          offer_vld  = 1'b1;
          offer_byte = SYNC_BYTE;
          state_nxt  = S_SYNC;
        end
      end
      S_SYNC: begin
        offer_vld  = 1'b1;
        offer_sum  = 1'b1;
        offer_byte = hdr_byte;
        if (room) state_nxt = S_HDR;
      end
      S_HDR: begin
        offer_vld  = 1'b1;
        offer_sum  = 1'b1;
        offer_byte = len_q;
        if (room) state_nxt = S_LEN;
      end
      S_LEN: begin
        offer_vld = 1'b1;
        if (len_q == 8'd0) begin
          // Empty payload: checksum follows LEN directly.
          offer_byte = csum;
          if (room) state_nxt = S_DRAIN;
        end else begin
          offer_pay  = 1'b1;
          offer_sum  = 1'b1;
          offer_byte = cur_payload;
          if (room) state_nxt = (len_q == 8'd1) ? S_CSUM : S_DATA;
        end
      end
      S_DATA: begin
        offer_vld  = 1'b1;
        offer_pay  = 1'b1;
        offer_sum  = 1'b1;
        offer_byte = cur_payload;
        if (room && ((cnt + 8'd1) == len_q)) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        offer_vld  = 1'b1;
        offer_byte = csum;
        if (room) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (accept) state_nxt = S_DONE;
      end
      S_DONE: begin
        // req is deliberately ignored here so a stale request is not re-granted.
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pop  = (load && offer_pay) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign done = (state == S_DONE)   ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_n       <= 1'b1;
      data_out   <= 8'h00;
      grant      <= 1'b0;
      last_grant <= 1'b1;  // makes source 0 the first winner
      len_q      <= 8'h00;
      cnt        <= 8'h00;
      csum       <= 8'h00;
      seq0       <= 7'd0;
      seq1       <= 7'd0;
    end else begin
      state <= state_nxt;

      if (load) begin
        data_out <= offer_byte;
        wr_n     <= 1'b0;
      end else if (accept) begin
        wr_n <= 1'b1;
      end

      if ((state == S_IDLE) && load) begin
        grant      <= pick;
        last_grant <= pick;
        len_q      <= pick ? len1 : len0;
        cnt        <= 8'h00;
        csum       <= 8'h00;
      end else if (load) begin
        if (offer_sum) csum <= csum ^ offer_byte;
        if (offer_pay) cnt  <= cnt + 8'd1;
      end

      if (state == S_DONE) begin
        if (grant) seq1 <= seq1 + 7'd1;
        else       seq0 <= seq0 + 7'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ft2232h_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft2232h_tx_arbiter
// Purpose  : Directed self-checking bench for ft2232h_tx_arbiter. Inputs are
//            driven just after the falling edge, outputs are sampled shortly
//            before the rising edge, and every accepted byte is collected for
//            comparison against hand-computed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft2232h_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txe_n = 1'b0;
  logic       wr_n;
  logic [7:0] data_out;
  logic [1:0] req = 2'b00;
  logic [7:0] len0 = 8'd0;
  logic [7:0] len1 = 8'd0;
  logic [7:0] src_data0;
  logic [7:0] src_data1;
  logic [1:0] pop;
  logic [1:0] done;
  logic       busy;

  logic [7:0] pay0 [256];
  logic [7:0] pay1 [256];
  logic [7:0] idx0 = 8'd0;
  logic [7:0] idx1 = 8'd0;

  assign src_data0 = pay0[idx0];
  assign src_data1 = pay1[idx1];

  always #5 clk = ~clk;

  ft2232h_tx_arbiter #(.SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .txe_n     (txe_n),
    .wr_n      (wr_n),
    .data_out  (data_out),
    .req       (req),
    .len0      (len0),
    .len1      (len1),
    .src_data0 (src_data0),
    .src_data1 (src_data1),
    .pop       (pop),
    .done      (done),
    .busy      (busy)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] got [$];
  int         got_t [$];
  int         pops [2];
  int         dones [2];
  int         tick_no = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Caller sits at falling edge + 1; sample at rising edge - 1, then return.
  task automatic tick();
    logic [1:0] p;
    #3;
    if (!wr_n && !txe_n) begin
      got.push_back(data_out);
      got_t.push_back(tick_no);
    end
    p = pop;
    for (int i = 0; i < 2; i++) begin
      if (p[i])    pops[i]++;
      if (done[i]) dones[i]++;
    end
    @(posedge clk);
    #1;
    if (p[0]) idx0 = idx0 + 8'd1;
    if (p[1]) idx1 = idx1 + 8'd1;
    tick_no++;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    got.delete();
    got_t.delete();
    pops[0] = 0; pops[1] = 0;
    dones[0] = 0; dones[1] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    txe_n = 1'b0;
    tick();
    tick();
    idx0  = 8'd0;
    idx1  = 8'd0;
    rst_n = 1'b1;
    clear_log();
  endtask

  // Request one frame on src and run until its done pulse (bounded).
  task automatic run_frame(input int src, input bit toggle, input int budget);
    int d0;
    d0 = dones[src];
    req[src] = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (toggle) txe_n = ~txe_n;
      tick();
      if (dones[src] != d0) begin
        req[src] = 1'b0;
        txe_n    = 1'b0;
        return;
      end
    end
    check($sformatf("timeout src%0d", src), 32'd0, 32'd1);
    req[src] = 1'b0;
    txe_n    = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] e [16], input int n);
    check({tag, " count"}, got.size(), n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s byte%0d", tag, i), (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, e[i]});
    end
  endtask

  initial begin
    logic [7:0] e [16];
    int phase;

    @(negedge clk);
    #1;

    // Reset held with requests pending and TXE# low.
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("reset outs%0d", k), {18'd0, wr_n, data_out, pop, done, busy},
            {18'd0, 1'b1, 8'h00, 2'b00, 2'b00, 1'b0});
    end

    // Single frame on source 0, then a LEN=0 frame to observe seq0=1.
    do_reset();
    pay0[0] = 8'h11; pay0[1] = 8'h22; pay0[2] = 8'h33;
    len0 = 8'd3;
    req  = 2'b01;
    tick();
    check("latency sync", {23'd0, wr_n, data_out}, {23'd0, 1'b0, 8'hA5});
    check("busy", {31'd0, busy}, 32'd1);
    run_frame(0, 1'b0, 40);
    e = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    expect_frame("single", e, 7);
    check("single pops", pops[0], 3);
    check("single pops1", pops[1], 0);
    check("single dones", dones[0], 1);
    if (got_t.size() == 7) check("single back-to-back", got_t[6] - got_t[0], 6);
    len0 = 8'd0;
    run_frame(0, 1'b0, 40);
    e = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03,
          8'hA5, 8'h01, 8'h00, 8'h01, 0, 0, 0, 0, 0};
    expect_frame("seq0", e, 11);
    if (got_t.size() == 11) check("frame gap", got_t[7] - got_t[6], 3);

    // Contention: both request, source 0 re-requests after its done.
    do_reset();
    len0 = 8'd1; len1 = 8'd1;
    pay0[0] = 8'h3C; pay0[1] = 8'h5A; pay1[0] = 8'h77;
    req   = 2'b11;
    phase = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (phase == 1) begin
        req[0] = 1'b1;
        phase  = 2;
      end
      if (dones[0] == 1 && phase == 0) begin
        req[0] = 1'b0;
        phase  = 1;
      end
      if (dones[1] == 1) req[1] = 1'b0;
      if (dones[0] == 2) begin
        req[0] = 1'b0;
        break;
      end
    end
    e = '{8'hA5, 8'h00, 8'h01, 8'h3C, 8'h3D,
          8'hA5, 8'h80, 8'h01, 8'h77, 8'hF6,
          8'hA5, 8'h01, 8'h01, 8'h5A, 8'h5A, 0};
    expect_frame("contention", e, 15);

    // Backpressure: TXE# high for 5 cycles after the second payload load.
    do_reset();
    len0 = 8'd4;
    pay0[0] = 8'hAA; pay0[1] = 8'hBB; pay0[2] = 8'hCC; pay0[3] = 8'hDD;
    req = 2'b01;
    for (int k = 0; k < 20 && pops[0] < 2; k++) tick();
    check("stall setup pops", pops[0], 2);
    txe_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall hold%0d", k), {23'd0, wr_n, data_out}, {23'd0, 1'b0, 8'hBB});
      check($sformatf("stall pops%0d", k), pops[0], 2);
    end
    txe_n = 1'b0;
    run_frame(0, 1'b0, 40);
    e = '{8'hA5, 8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h04, 0, 0, 0, 0, 0, 0, 0, 0};
    expect_frame("stall", e, 8);
    check("stall pops total", pops[0], 4);

    // LEN=0 on source 1 and seq wrap after 128 frames, TXE# toggling.
    do_reset();
    len1 = 8'd0;
    for (int f = 0; f < 129; f++) begin
      got.delete();
      got_t.delete();
      run_frame(1, 1'b1, 40);
      if (f == 0) begin
        e = '{8'hA5, 8'h80, 8'h00, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        expect_frame("len0", e, 4);
      end
      if (f == 127) begin
        e = '{8'hA5, 8'hFF, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        expect_frame("seq127", e, 4);
      end
      if (f == 128) begin
        e = '{8'hA5, 8'h80, 8'h00, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        expect_frame("seq wrap", e, 4);
      end
    end
    check("wrap dones", dones[1], 129);
    check("wrap pops", pops[1], 0);

    // Reset in the middle of a payload, then a fresh source 1 frame.
    do_reset();
    len0 = 8'd5;
    for (int i = 0; i < 5; i++) pay0[i] = 8'(i + 1);
    req = 2'b01;
    for (int k = 0; k < 20 && pops[0] < 2; k++) tick();
    check("midrst setup", pops[0], 2);
    rst_n = 1'b0;
    #1;
    check("midrst immediate", {22'd0, wr_n, busy, data_out}, {22'd0, 1'b1, 1'b0, 8'h00});
    @(negedge clk);
    #1;
    req = 2'b00;
    tick();
    tick();
    check("midrst no done", dones[0], 0);
    idx0 = 8'd0;
    idx1 = 8'd0;
    rst_n = 1'b1;
    clear_log();
    len1 = 8'd1;
    pay1[0] = 8'h42;
    run_frame(1, 1'b0, 40);
    e = '{8'hA5, 8'h80, 8'h01, 8'h42, 8'hC3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    expect_frame("post reset", e, 5);
    check("post reset done0", dones[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
